// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship VGA display path: screen encodings,
// active-area bounds and fixed colours.
package battleship_pkg;

    typedef enum logic [2:0] {
        SCR_TITLE   = 3'd0,
        SCR_P1_TURN = 3'd1,
        SCR_P2_TURN = 3'd2,
        SCR_HANDOFF = 3'd3,
        SCR_P1_WINS = 3'd4,
        SCR_P2_WINS = 3'd5
    } screen_e;

    localparam logic [15:0] H_ACT_FIRST  = 16'd144;
    localparam logic [15:0] H_ACT_LAST   = 16'd783;
    localparam logic [15:0] V_ACT_FIRST  = 16'd35;
    localparam logic [15:0] V_ACT_LAST   = 16'd514;
    localparam logic [15:0] H_TOTAL      = 16'd800;
    localparam logic [15:0] V_TOTAL      = 16'd525;
    localparam logic [11:0] HANDOFF_GRAY = 12'h333;

    function automatic logic in_active(input logic [15:0] h, input logic [15:0] v);
        return (h >= H_ACT_FIRST) && (h <= H_ACT_LAST) &&
               (v >= V_ACT_FIRST) && (v <= V_ACT_LAST);
    endfunction

endpackage

// File: rtl/screen_sequencer_frame_edge_det.sv
// Produces a single-cycle frame_start on the first clk where the VGA counters
// sit at the origin; the counters may dwell there for several cycles.
module frame_edge_det (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] h_count,
    input  logic [15:0] v_count,
    output logic        frame_start
);

    logic at_origin;
    logic at_origin_reg;

    assign at_origin   = (h_count == 16'd0) && (v_count == 16'd0);
    assign frame_start = at_origin && !at_origin_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_origin_reg <= 1'b0;
        end else begin
            at_origin_reg <= at_origin;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Chooses which full-screen renderer drives the VGA pins. Game events are
// latched and acted on only at frame start so screen changes never tear.
module screen_sequencer
    import battleship_pkg::*;
#(
    parameter int HANDOFF_FRAMES = 120,
    parameter int WIN_FRAMES     = 600,
    parameter int FCNT_W         = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] H_Counter_Value,
    input  logic [15:0] V_Counter_Value,
    input  logic        start_game,
    input  logic        shot_done,
    input  logic        p1_win,
    input  logic        p2_win,
    input  logic [11:0] title_rgb,
    input  logic [11:0] p1_rgb,
    input  logic [11:0] p2_rgb,
    input  logic [11:0] p1w_rgb,
    input  logic [11:0] p2w_rgb,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic [2:0]  screen_id,
    output logic        frame_start,
    output logic        input_enable
);

    localparam logic [FCNT_W-1:0] HANDOFF_LAST = FCNT_W'(HANDOFF_FRAMES - 1);
    localparam logic [FCNT_W-1:0] WIN_LAST     = FCNT_W'(WIN_FRAMES - 1);

    screen_e           state_reg, state_next;
    logic [FCNT_W-1:0] fcnt_reg, fcnt_next;
    logic              next_p2_reg, next_p2_next;
    logic              start_pend_reg, start_pend_next;
    logic              shot_pend_reg, shot_pend_next;
    logic              p1w_pend_reg, p1w_pend_next;
    logic              p2w_pend_reg, p2w_pend_next;
    logic [11:0]       rgb_reg, rgb_next;
    logic [11:0]       src_rgb;

    frame_edge_det u_frame_edge_det (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_count     (H_Counter_Value),
        .v_count     (V_Counter_Value),
        .frame_start (frame_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SCR_TITLE;
            fcnt_reg       <= '0;
            next_p2_reg    <= 1'b1;
            start_pend_reg <= 1'b0;
            shot_pend_reg  <= 1'b0;
            p1w_pend_reg   <= 1'b0;
            p2w_pend_reg   <= 1'b0;
            rgb_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            fcnt_reg       <= fcnt_next;
            next_p2_reg    <= next_p2_next;
            start_pend_reg <= start_pend_next;
            shot_pend_reg  <= shot_pend_next;
            p1w_pend_reg   <= p1w_pend_next;
            p2w_pend_reg   <= p2w_pend_next;
            rgb_reg        <= rgb_next;
        end
    end

    // Pulses arriving on the evaluating frame_start cycle survive into the next frame.
    always_comb begin
        start_pend_next = frame_start ? start_game : (start_pend_reg | start_game);
        shot_pend_next  = frame_start ? shot_done  : (shot_pend_reg  | shot_done);
        p1w_pend_next   = frame_start ? p1_win     : (p1w_pend_reg   | p1_win);
        p2w_pend_next   = frame_start ? p2_win     : (p2w_pend_reg   | p2_win);
    end

    always_comb begin
        state_next   = state_reg;
        next_p2_next = next_p2_reg;
        if (frame_start) begin
            case (state_reg)
                SCR_TITLE: begin
                    if (start_pend_reg) state_next = SCR_P1_TURN;
                end
                SCR_P1_TURN, SCR_P2_TURN: begin
                    if (p1w_pend_reg) begin
                        state_next = SCR_P1_WINS;
                    end else if (p2w_pend_reg) begin
                        state_next = SCR_P2_WINS;
                    end else if (shot_pend_reg) begin
                        state_next   = SCR_HANDOFF;
                        next_p2_next = (state_reg == SCR_P1_TURN);
                    end
                end
                SCR_HANDOFF: begin
                    if (p1w_pend_reg) begin
                        state_next = SCR_P1_WINS;
                    end else if (p2w_pend_reg) begin
                        state_next = SCR_P2_WINS;
                    end else if (fcnt_reg == HANDOFF_LAST) begin
                        state_next = next_p2_reg ? SCR_P2_TURN : SCR_P1_TURN;
                    end
                end
                SCR_P1_WINS, SCR_P2_WINS: begin
                    if (fcnt_reg == WIN_LAST) state_next = SCR_TITLE;
                end
                default: state_next = SCR_TITLE;
            endcase
        end
    end

    always_comb begin
        fcnt_next = fcnt_reg;
        if (state_next != state_reg) begin
            fcnt_next = '0;
        end else if (frame_start && (fcnt_reg != {FCNT_W{1'b1}})) begin
            fcnt_next = fcnt_reg + 1'b1;
        end
    end

    always_comb begin
        src_rgb = '0;
        case (state_reg)
            SCR_TITLE:   src_rgb = title_rgb;
            SCR_P1_TURN: src_rgb = p1_rgb;
            SCR_P2_TURN: src_rgb = p2_rgb;
            SCR_HANDOFF: src_rgb = HANDOFF_GRAY;
            SCR_P1_WINS: src_rgb = p1w_rgb;
            SCR_P2_WINS: src_rgb = p2w_rgb;
            default:     src_rgb = '0;
        endcase
        rgb_next = in_active(H_Counter_Value, V_Counter_Value) ? src_rgb : 12'h000;
    end

    assign Red          = rgb_reg[11:8];
    assign Green        = rgb_reg[7:4];
    assign Blue         = rgb_reg[3:0];
    assign screen_id    = state_reg;
    assign input_enable = (state_reg == SCR_P1_TURN) || (state_reg == SCR_P2_TURN);

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with short hand-off and win timers.
module tb_screen_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] h = 16'd10;
    logic [15:0] v = 16'd10;
    logic        start_game = 1'b0;
    logic        shot_done = 1'b0;
    logic        p1_win = 1'b0;
    logic        p2_win = 1'b0;
    logic [11:0] title_rgb = 12'h123;
    logic [11:0] p1_rgb    = 12'hABC;
    logic [11:0] p2_rgb    = 12'h456;
    logic [11:0] p1w_rgb   = 12'h789;
    logic [11:0] p2w_rgb   = 12'hDEF;
    logic [3:0]  red, green, blue;
    logic [2:0]  screen_id;
    logic        frame_start;
    logic        input_enable;

    int total_cnt = 0;
    int fail_cnt  = 0;

    screen_sequencer #(
        .HANDOFF_FRAMES (3),
        .WIN_FRAMES     (4),
        .FCNT_W         (10)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .H_Counter_Value (h),
        .V_Counter_Value (v),
        .start_game      (start_game),
        .shot_done       (shot_done),
        .p1_win          (p1_win),
        .p2_win          (p2_win),
        .title_rgb       (title_rgb),
        .p1_rgb          (p1_rgb),
        .p2_rgb          (p2_rgb),
        .p1w_rgb         (p1w_rgb),
        .p2w_rgb         (p2w_rgb),
        .Red             (red),
        .Green           (green),
        .Blue            (blue),
        .screen_id       (screen_id),
        .frame_start     (frame_start),
        .input_enable    (input_enable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_rgb(input string tag, input logic [11:0] exp);
        check(tag, {4'h0, red, green, blue}, {4'h0, exp});
    endtask

    // One frame: dwell at the origin for two clks, then sit in the active area.
    task automatic frame();
        h = 16'd0; v = 16'd0;
        tick(); tick();
        h = 16'd200; v = 16'd100;
        tick(); tick();
    endtask

    task automatic pulse_start();
        start_game = 1'b1; tick(); start_game = 1'b0; tick();
    endtask

    task automatic pulse_shot();
        shot_done = 1'b1; tick(); shot_done = 1'b0; tick();
    endtask

    initial begin
        // Reset and frame_start edge detection
        tick(); tick();
        check_rgb("rst_rgb", 12'h000);
        check("rst_id", {13'd0, screen_id}, 16'd0);
        check("rst_ien", {15'd0, input_enable}, 16'd0);
        rst_n = 1'b1;
        tick();
        check("fs_idle", {15'd0, frame_start}, 16'd0);
        h = 16'd0; v = 16'd0;
        #1;
        check("fs_first", {15'd0, frame_start}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fs_hold", {15'd0, frame_start}, 16'd0);
            check("id_hold", {13'd0, screen_id}, 16'd0);
        end
        check_rgb("blank_origin", 12'h000);

        // Title colour, then start latched mid-frame
        h = 16'd200; v = 16'd100;
        tick();
        check_rgb("title_rgb", 12'h123);
        pulse_start();
        check("start_wait", {13'd0, screen_id}, 16'd0);
        h = 16'd0; v = 16'd0;
        tick();
        check("to_p1", {13'd0, screen_id}, 16'd1);
        check("p1_ien", {15'd0, input_enable}, 16'd1);
        h = 16'd200; v = 16'd100;
        tick();
        check_rgb("p1_rgb", 12'hABC);

        // Hand-off lasts three frames, then player 2
        pulse_shot();
        for (int i = 0; i < 3; i++) begin
            frame();
            check("handoff_id", {13'd0, screen_id}, 16'd3);
            check_rgb("handoff_gray", 12'h333);
        end
        check("handoff_ien", {15'd0, input_enable}, 16'd0);
        frame();
        check("to_p2", {13'd0, screen_id}, 16'd2);
        check_rgb("p2_rgb", 12'h456);

        // Win outranks shot; win screen lasts four frames and ignores start
        pulse_shot();
        p2_win = 1'b1; tick(); p2_win = 1'b0; tick();
        frame();
        check("to_p2wins", {13'd0, screen_id}, 16'd5);
        check_rgb("p2w_rgb", 12'hDEF);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            frame();
            check("win_hold", {13'd0, screen_id}, 16'd5);
        end
        frame();
        check("win_to_title", {13'd0, screen_id}, 16'd0);
        frame();
        check("start_dropped", {13'd0, screen_id}, 16'd0);

        // Blanking and active-area edges
        h = 16'd100; v = 16'd100; tick();
        check_rgb("blank_h100", 12'h000);
        h = 16'd200; v = 16'd520; tick();
        check_rgb("blank_v520", 12'h000);
        h = 16'd144; v = 16'd35; tick();
        check_rgb("edge_first", 12'h123);
        h = 16'd783; v = 16'd514; tick();
        check_rgb("edge_last", 12'h123);
        h = 16'd784; v = 16'd514; tick();
        check_rgb("edge_h784", 12'h000);
        h = 16'd783; v = 16'd515; tick();
        check_rgb("edge_v515", 12'h000);

        // Asynchronous reset in the middle of a hand-off
        pulse_start();
        frame();
        pulse_shot();
        frame();
        check("pre_rst_handoff", {13'd0, screen_id}, 16'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_rgb("async_rgb", 12'h000);
        check("async_id", {13'd0, screen_id}, 16'd0);
        check("async_ien", {15'd0, input_enable}, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_id", {13'd0, screen_id}, 16'd0);
        frame();
        check("post_rst_wait", {13'd0, screen_id}, 16'd0);
        pulse_start();
        frame();
        check("post_rst_p1", {13'd0, screen_id}, 16'd1);
        pulse_shot();
        for (int i = 0; i < 3; i++) frame();
        check("post_rst_cnt", {13'd0, screen_id}, 16'd3);
        frame();
        check("post_rst_p2", {13'd0, screen_id}, 16'd2);

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
